// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues word-aligned fetch requests to an
// instruction memory and queues the in-order responses as {instr, pc} pairs
// for a downstream consumer. It also handles branch/jump redirects by
// discarding responses that were already in flight.
//
// Flow control is credit based. A request may only be issued while
// (queued entries + unanswered requests) < DEPTH. Every response therefore
// always has a FIFO slot waiting for it.
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   reset_n          asynchronous active-low reset
//   imem_req         fetch request valid (combinational)
//   imem_addr        fetch address (the fetch_pc register)
//   imem_ready       memory accepts the request this cycle
//   imem_rvalid      in-order response present
//   imem_rdata       response instruction word
//   instr_valid      queue head valid
//   instr            queue head instruction
//   instr_pc         queue head address
//   instr_ready      consumer pops the head when instr_valid is set
//   redirect         single-cycle taken branch/jump pulse
//   redirect_target  new fetch address (low two bits ignored)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int unsigned        DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [SUM_W-1:0]  CREDITS   = SUM_W'(DEPTH);

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Queue storage. It has no reset because occ qualifies every entry.
    logic [31:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];

    // Next-state values
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic [ADDR_W-1:0] resp_pc_nxt;
    logic [CNT_W-1:0]  occ_nxt;
    logic [CNT_W-1:0]  outstanding_nxt;
    logic [CNT_W-1:0]  discard_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr_nxt;

    // Handshake terms
    logic [SUM_W-1:0]  credit_sum;
    logic [ADDR_W-1:0] target_aligned;
    logic              accept;
    logic              pop;
    logic              resp_drop;
    logic              push;

    // Outstanding requests consume credits as well as queued entries. A
    // response can then never find the queue full.
    assign credit_sum     = {1'b0, occ} + {1'b0, outstanding};
    assign target_aligned = redirect_target & WORD_MASK;

    assign imem_req    = !redirect && (credit_sum < CREDITS);
    assign imem_addr   = fetch_pc;

    assign instr_valid = (occ != '0) && !redirect;
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    assign accept    = imem_req && imem_ready;
    assign pop       = instr_valid && instr_ready;
    assign resp_drop = imem_rvalid && (discard != '0);
    // A response that arrives in the redirect cycle belongs to the old
    // path. The redirect folds it into the discard accounting instead.
    assign push      = imem_rvalid && (discard == '0) && !redirect;

    always_comb begin
        fetch_pc_nxt    = fetch_pc;
        resp_pc_nxt     = resp_pc;
        occ_nxt         = occ;
        outstanding_nxt = outstanding;
        discard_nxt     = discard;
        rd_ptr_nxt      = rd_ptr;
        wr_ptr_nxt      = wr_ptr;

        if (redirect) begin
            fetch_pc_nxt = target_aligned;
            resp_pc_nxt  = target_aligned;
            occ_nxt      = '0;
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            // Every request still unanswered after this edge belongs to
            // the abandoned path. Those responses must be dropped.
            if (imem_rvalid) begin
                outstanding_nxt = outstanding - CNT_ONE;
                discard_nxt     = outstanding - CNT_ONE;
            end else begin
                discard_nxt     = outstanding;
            end
        end else begin
            if (accept) begin
                fetch_pc_nxt = fetch_pc + PC_STEP;
            end

            if (push) begin
                wr_ptr_nxt  = wr_ptr + PTR_ONE;
                resp_pc_nxt = resp_pc + PC_STEP;
            end

            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   occ_nxt = occ + CNT_ONE;
                2'b01:   occ_nxt = occ - CNT_ONE;
                default: occ_nxt = occ;
            endcase

            case ({accept, imem_rvalid})
                2'b10:   outstanding_nxt = outstanding + CNT_ONE;
                2'b01:   outstanding_nxt = outstanding - CNT_ONE;
                default: outstanding_nxt = outstanding;
            endcase

            if (resp_drop) begin
                discard_nxt = discard - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_VEC;
            resp_pc     <= RESET_VEC;
            occ         <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            resp_pc     <= resp_pc_nxt;
            occ         <= occ_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. It uses two instances:
//   dut   ADDR_W=32, RESET_VEC=0, DEPTH=4. Driven with randomized traffic
//         and checked every cycle against a queue-based reference model.
//   s8    ADDR_W=8. Takes a short directed check of address wrap and of
//         mid-stream reset.
//
// The reference model tags each in-flight request with its address and a
// stale flag that a redirect sets. A response whose request is not stale
// delivers {word_of(addr), addr} to the expected instruction queue.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 32-bit instance ----------------
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;

    fetch_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    // ---------------- 8-bit instance ----------------
    logic        s8_reset_n;
    logic        s8_imem_req;
    logic [7:0]  s8_imem_addr;
    logic        s8_imem_ready;
    logic        s8_imem_rvalid;
    logic [31:0] s8_imem_rdata;
    logic        s8_instr_valid;
    logic [31:0] s8_instr;
    logic [7:0]  s8_instr_pc;
    logic        s8_instr_ready;
    logic        s8_redirect;
    logic [7:0]  s8_redirect_target;

    fetch_unit #(.ADDR_W(8), .RESET_VEC(8'h00), .DEPTH(DEPTH)) s8 (
        .clk             (clk),
        .reset_n         (s8_reset_n),
        .imem_req        (s8_imem_req),
        .imem_addr       (s8_imem_addr),
        .imem_ready      (s8_imem_ready),
        .imem_rvalid     (s8_imem_rvalid),
        .imem_rdata      (s8_imem_rdata),
        .instr_valid     (s8_instr_valid),
        .instr           (s8_instr),
        .instr_pc        (s8_instr_pc),
        .instr_ready     (s8_instr_ready),
        .redirect        (s8_redirect),
        .redirect_target (s8_redirect_target)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } entry_t;

    flight_t     inflight[$];
    entry_t      mq[$];
    logic [31:0] mfetch;

    logic    exp_req;
    logic    exp_valid;
    logic    m_acc;
    logic    m_pop;
    flight_t resp;
    int      mode;
    int      p_ready, p_rv, p_iready, p_redir;

    initial begin
        reset_n         = 1'b0;
        imem_ready      = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = '0;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;

        s8_reset_n         = 1'b0;
        s8_imem_ready      = 1'b0;
        s8_imem_rvalid     = 1'b0;
        s8_imem_rdata      = '0;
        s8_instr_ready     = 1'b0;
        s8_redirect        = 1'b0;
        s8_redirect_target = '0;

        // Values held while in reset.
        #1;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("s8_rst_addr", s8_imem_addr, 8'h00);
        check("s8_rst_valid", s8_instr_valid, 1'b0);

        @(negedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        s8_reset_n = 1'b1;
        #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        check("s8_first_req", s8_imem_req, 1'b1);

        // ---- 8-bit wrap: redirect to 0xFF (aligned to 0xFC), then step ----
        @(negedge clk);
        s8_redirect        = 1'b1;
        s8_redirect_target = 8'hFF;
        #1;
        check("s8_redir_req", s8_imem_req, 1'b0);
        @(negedge clk);
        s8_redirect   = 1'b0;
        s8_imem_ready = 1'b1;
        #1;
        check("s8_tgt_addr", s8_imem_addr, 8'hFC);
        check("s8_tgt_req", s8_imem_req, 1'b1);
        @(negedge clk);
        s8_imem_ready  = 1'b0;
        s8_imem_rvalid = 1'b1;
        s8_imem_rdata  = 32'hCAFE_00FC;
        #1;
        check("s8_wrap_addr", s8_imem_addr, 8'h00);
        @(negedge clk);
        s8_imem_rvalid = 1'b0;
        s8_imem_rdata  = 32'hDEAD_BEEF;
        s8_imem_ready  = 1'b1;
        #1;
        check("s8_head_valid", s8_instr_valid, 1'b1);
        check("s8_head_pc", s8_instr_pc, 8'hFC);
        check("s8_head_instr", s8_instr, 32'hCAFE_00FC);
        @(negedge clk);
        s8_reset_n = 1'b0;
        #1;
        check("s8_midrst_valid", s8_instr_valid, 1'b0);
        check("s8_midrst_addr", s8_imem_addr, 8'h00);
        @(negedge clk);
        s8_reset_n    = 1'b1;
        s8_imem_ready = 1'b0;
        #1;
        check("s8_post_rst_req", s8_imem_req, 1'b1);
        check("s8_post_rst_valid", s8_instr_valid, 1'b0);

        // ---- randomized traffic on the 32-bit instance ----
        mfetch = 32'h0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            mode = (cyc / 500) % 4;
            case (mode)
                0:       begin p_ready = 100; p_rv = 100; p_iready = 100; p_redir = 2;  end
                1:       begin p_ready = 90;  p_rv = 80;  p_iready = 10;  p_redir = 3;  end
                2:       begin p_ready = 50;  p_rv = 50;  p_iready = 50;  p_redir = 5;  end
                default: begin p_ready = 80;  p_rv = 70;  p_iready = 70;  p_redir = 20; end
            endcase

            if (cyc > 10 && $urandom_range(0, 299) == 0) begin
                // Asynchronous reset in the middle of traffic. The memory
                // drops everything that was in flight.
                reset_n     = 1'b0;
                redirect    = 1'b0;
                imem_rvalid = 1'b0;
                imem_ready  = 1'($urandom);
                instr_ready = 1'($urandom);
                #1;
                check("midrst_valid", instr_valid, 1'b0);
                check("midrst_addr", imem_addr, 32'h0);
                mq.delete();
                inflight.delete();
                mfetch = 32'h0;
                continue;
            end
            reset_n = 1'b1;

            imem_ready  = ($urandom_range(0, 99) < p_ready);
            imem_rvalid = (inflight.size() != 0) && ($urandom_range(0, 99) < p_rv);
            imem_rdata  = imem_rvalid ? word_of(inflight[0].addr) : $urandom;
            instr_ready = ($urandom_range(0, 99) < p_iready);
            redirect    = ($urandom_range(0, 99) < p_redir);
            redirect_target = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            #1;

            exp_req   = !redirect && ((mq.size() + inflight.size()) < DEPTH);
            exp_valid = (mq.size() != 0) && !redirect;
            check("imem_req", imem_req, exp_req);
            check("imem_addr", imem_addr, mfetch);
            check("instr_valid", instr_valid, exp_valid);
            if (exp_valid) begin
                check("instr_pc", instr_pc, mq[0].pc);
                check("instr", instr, mq[0].w);
            end

            // Advance the model over the coming edge.
            m_acc = exp_req && imem_ready;
            m_pop = exp_valid && instr_ready;
            resp  = '{addr: 32'h0, stale: 1'b1};
            if (imem_rvalid) begin
                resp = inflight.pop_front();
            end
            if (redirect) begin
                mq.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                mfetch = redirect_target & 32'hFFFF_FFFC;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (imem_rvalid && !resp.stale)
                    mq.push_back('{pc: resp.addr, w: word_of(resp.addr)});
                if (m_acc) begin
                    inflight.push_back('{addr: mfetch, stale: 1'b0});
                    mfetch = mfetch + 32'd4;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
